// File: rtl/matmul_sequencer_if.sv
// Operand-read / result-write bundle between matmul_sequencer (master) and the
// operand and result memories (slave).
interface matmul_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);
  logic              start;
  logic [3:0]        a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_sel;
  logic [3:0]        b_addr;
  logic [DATA_W-1:0] b_data;
  logic              res_we;
  logic [4:0]        res_addr;
  logic [ACC_W-1:0]  res_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, a_data, b_data,
    output a_addr, b_sel, b_addr, res_we, res_addr, res_data, busy, done
  );

  modport slave (
    output start, a_data, b_data,
    input  a_addr, b_sel, b_addr, res_we, res_addr, res_data, busy, done
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Steps a shared 8x8 MAC through every dot product of A*B (and A*v first when
// MATVEC_EN is defined), writing one ACC_W-bit result per dot.
module matmul_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic               clk,
  input  logic               reset,
  matmul_sequencer_if.master bus
);
`ifdef MATVEC_EN
  localparam int NDOTS = 20;
`else
  localparam int NDOTS = 16;
`endif
  localparam logic [6:0] LAST_TERM = 7'(NDOTS * 4 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              r_state, w_state_nxt;
  logic [6:0]          r_term, w_term_nxt;
  logic                w_issue;
  logic [3:0]          r_a_addr, r_b_addr;
  logic [4:0]          r_res_idx_p0, r_res_idx_p1;
  logic [1:0]          r_k_p1;
  logic                r_vld_p1, r_last_p1;
  logic [ACC_W-1:0]    r_acc, r_res_data;
  logic [4:0]          r_res_addr;
  logic                r_res_we, r_done;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_sum;

  // Linear term index -> {a_addr, b_addr, res_addr}; j is 4r+c of the A*B dot
  function automatic logic [12:0] term_map(input logic [6:0] term);
`ifdef MATVEC_EN
    logic [4:0] dot;
`endif
    logic [1:0] k;
    logic [3:0] j;
    k = term[1:0];
`ifdef MATVEC_EN
    dot = 5'(term >> 2);
    if (dot < 5'd4) return {dot[1:0], k, 2'b00, k, dot};
    j = 4'(dot - 5'd4);
`else
    j = 4'(term >> 2);
`endif
    return {j[3:2], k, k, j[1:0], 5'd4 + 5'(j)};
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_term_nxt  = r_term;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE: if (bus.start) begin
        w_state_nxt = RUN;
        w_term_nxt  = '0;
        w_issue     = 1'b1;
      end
      RUN: if (r_term == LAST_TERM) begin
        w_state_nxt = DRAIN;
      end else begin
        w_term_nxt = r_term + 7'd1;
        w_issue    = 1'b1;
      end
      DRAIN: if (r_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand read addresses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_term       <= '0;
      r_a_addr     <= '0;
      r_b_addr     <= '0;
      r_res_idx_p0 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_term  <= w_term_nxt;
      if (w_issue) {r_a_addr, r_b_addr, r_res_idx_p0} <= term_map(w_term_nxt);
    end
  end

`ifdef MATVEC_EN
  logic r_b_sel;
  always_ff @(posedge clk) begin
    if (reset)        r_b_sel <= 1'b0;
    else if (w_issue) r_b_sel <= (w_term_nxt >= 7'd16);
  end
  assign bus.b_sel = r_b_sel;
`else
  assign bus.b_sel = 1'b1;
`endif

  // Stage p1: term tags line up with the operand data returned by the memories
  always_ff @(posedge clk) begin
    if (reset) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= (r_state == RUN);
    r_k_p1       <= r_term[1:0];
    r_last_p1    <= (r_term == LAST_TERM);
    r_res_idx_p1 <= r_res_idx_p0;
  end

  assign w_prod = (2*DATA_W)'(bus.a_data) * (2*DATA_W)'(bus.b_data);
  assign w_sum  = ((r_k_p1 == 2'd0) ? '0 : r_acc) + ACC_W'(w_prod);

  // Stage p2: accumulate, register the finished dot for the result write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_res_we   <= 1'b0;
      r_res_addr <= '0;
      r_res_data <= '0;
      r_done     <= 1'b0;
    end else begin
      r_res_we <= 1'b0;
      r_done   <= 1'b0;
      if (r_vld_p1) begin
        r_acc <= w_sum;
        if (r_k_p1 == 2'd3) begin
          r_res_we   <= 1'b1;
          r_res_data <= w_sum;
          r_res_addr <= r_res_idx_p1;
          r_done     <= r_last_p1;
        end
      end
    end
  end

  assign bus.a_addr   = r_a_addr;
  assign bus.b_addr   = r_b_addr;
  assign bus.res_we   = r_res_we;
  assign bus.res_addr = r_res_addr;
  assign bus.res_data = r_res_data;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: operand memories, dot-product reference model and
// a per-cycle compare of addresses, writes, busy and done.
module tb_matmul_sequencer;
`ifdef MATVEC_EN
  localparam int   N        = 20;
  localparam int   FIRST    = 0;
  localparam int   DONE_LIT = 82;
  localparam logic BSEL_RST = 1'b0;
`else
  localparam int   N        = 16;
  localparam int   FIRST    = 4;
  localparam int   DONE_LIT = 66;
  localparam logic BSEL_RST = 1'b1;
`endif
  localparam logic [19:0] SENT = 20'hFFFFF;

  logic clk = 1'b0;
  logic reset;

  matmul_sequencer_if #(.DATA_W(8), .ACC_W(20)) bus ();
  matmul_sequencer #(.DATA_W(8), .ACC_W(20)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0]  a_m [16];
  logic [7:0]  v_m [4];
  logic [7:0]  b_m [16];
  logic [19:0] exp_res [20];
  logic [19:0] got [20];

  // Synchronous-read operand memories
  always @(posedge clk) begin
    bus.a_data <= a_m[bus.a_addr];
    bus.b_data <= bus.b_sel ? b_m[bus.b_addr] : v_m[bus.b_addr[1:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  int t_start = -1, abort_at = -1;
  bit chk_en = 1'b0;
  int wr_count = 0, done_rel = -1, first_we_rel = -1, first_we_addr = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compute_model();
    int s;
    for (int i = 0; i < 20; i++) begin
      s = 0;
      for (int k = 0; k < 4; k++) begin
        if (i < 4) s += int'(a_m[4*i+k]) * int'(v_m[k]);
        else       s += int'(a_m[4*((i-4)/4)+k]) * int'(b_m[4*k+(i-4)%4]);
      end
      exp_res[i] = 20'(s);
    end
  endtask

  task automatic load(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        1: begin a_m[i] = (i/4 == i%4) ? 8'd1 : 8'd0; b_m[i] = 8'd2; end
        2: begin a_m[i] = 8'd255; b_m[i] = 8'd255; end
        default: begin a_m[i] = 8'(i%4 + 1); b_m[i] = (i/4 == i%4) ? 8'd1 : 8'd0; end
      endcase
    end
    for (int i = 0; i < 4; i++) begin
      case (kind)
        1:       v_m[i] = 8'(i + 1);
        2:       v_m[i] = 8'd255;
        default: v_m[i] = (i == 3) ? 8'd1 : 8'd0;
      endcase
    end
    compute_model();
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic begin_run();
    wr_count = 0; done_rel = -1; first_we_rel = -1; first_we_addr = -1;
    for (int i = 0; i < 20; i++) got[i] = SENT;
    t_start = cyc; abort_at = -1;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  // Per-cycle compare against the schedule implied by the start cycle
  always @(negedge clk) begin
    int rel, term, idx, k, j;
    bit exp_we, exp_busy;
    if (chk_en) begin
      if (t_start < 0 || (abort_at >= 0 && cyc > abort_at)) begin
        chk("idle_res_we", int'(bus.res_we), 0);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_done", int'(bus.done), 0);
      end else begin
        rel      = cyc - t_start;
        exp_busy = (rel >= 1 && rel <= 4*N + 2);
        exp_we   = (rel >= 6 && rel <= 4*N + 2 && (rel - 6) % 4 == 0);
        chk("busy", int'(bus.busy), int'(exp_busy));
        chk("res_we", int'(bus.res_we), int'(exp_we));
        if (exp_we) begin
          idx = FIRST + (rel - 6) / 4;
          chk("res_addr", int'(bus.res_addr), idx);
          chk("res_data", int'(bus.res_data), int'(exp_res[idx]));
          chk("done", int'(bus.done), int'(idx == 19));
        end else begin
          chk("done_quiet", int'(bus.done), 0);
        end
        if (rel >= 1 && rel <= 4*N) begin
          term = rel - 1;
          idx  = FIRST + term / 4;
          k    = term % 4;
          if (idx < 4) begin
            chk("a_addr", int'(bus.a_addr), 4*idx + k);
            chk("b_sel", int'(bus.b_sel), 0);
            chk("b_addr", int'(bus.b_addr), k);
          end else begin
            j = idx - 4;
            chk("a_addr", int'(bus.a_addr), 4*(j/4) + k);
            chk("b_sel", int'(bus.b_sel), 1);
            chk("b_addr", int'(bus.b_addr), 4*k + j%4);
          end
        end
      end
      if (bus.res_we) begin
        wr_count++;
        if (bus.res_addr < 5'd20) got[bus.res_addr] = bus.res_data;
        if (first_we_rel < 0) begin
          first_we_rel  = cyc - t_start;
          first_we_addr = int'(bus.res_addr);
        end
      end
      if (bus.done) done_rel = cyc - t_start;
    end
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    load(1);
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    step(2);

    // Identity A, v=(1,2,3,4), B all 2
    load(1);
    chk("s1_model_pin", int'(exp_res[9]), 2);
    begin_run();
    step(4*N + 2);
    chk("s1_writes", wr_count, N);
    chk("s1_done_cycle", done_rel, DONE_LIT);
    chk("s1_first_we_cycle", first_we_rel, 6);
    chk("s1_first_we_addr", first_we_addr, FIRST);
    chk("s1_r4", int'(got[4]), 2);
    chk("s1_r19", int'(got[19]), 2);
`ifdef MATVEC_EN
    for (int i = 0; i < 4; i++) chk("s1_av", int'(got[i]), i + 1);
`else
    chk("s1_r0_untouched", int'(got[0]), int'(SENT));
    chk("s1_r3_untouched", int'(got[3]), int'(SENT));
`endif

    // All 255, started in the first cycle with busy low
    load(2);
    chk("s2_model_pin", int'(exp_res[19]), 32'h3F804);
    begin_run();
    step(4*N + 2);
    chk("s2_writes", wr_count, N);
    for (int i = FIRST; i < 20; i++) chk("s2_max", int'(got[i]), 32'h3F804);

    // A rows (1,2,3,4), B identity, v=(0,0,0,1); start re-pulsed while busy
    load(3);
    chk("s3_model_pin", int'(exp_res[6]), 3);
    begin_run();
    step(29);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(4*N + 2 - 30);
    chk("s3_writes", wr_count, N);
    chk("s3_done_cycle", done_rel, DONE_LIT);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) chk("s3_ab", int'(got[4 + 4*r + c]), c + 1);
`ifdef MATVEC_EN
    for (int i = 0; i < 4; i++) chk("s3_av", int'(got[i]), 4);
`endif

    // Reset in cycle 40 of a run, then a clean rerun
    load(1);
    begin_run();
    step(39);
    abort_at = cyc;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_a_addr", int'(bus.a_addr), 0);
    chk("rst_b_addr", int'(bus.b_addr), 0);
    chk("rst_b_sel", int'(bus.b_sel), int'(BSEL_RST));
    chk("rst_res_we", int'(bus.res_we), 0);
    chk("rst_res_addr", int'(bus.res_addr), 0);
    chk("rst_res_data", int'(bus.res_data), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_partial_writes", wr_count, 9);
    @(posedge clk);
    #1;
    step(2);
    begin_run();
    step(4*N + 2);
    chk("s5_writes", wr_count, N);
    chk("s5_done_cycle", done_rel, DONE_LIT);
    for (int i = FIRST; i < 20; i++) chk("s5_res", int'(got[i]), int'(exp_res[i]));
    chk("s5_r12", int'(got[12]), 2);

    step(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Sequencer for the lab's matrix datapath. After the UART loader has filled operand storage (4x4 matrix A, 4-vector v, 4x4 matrix B), it drives one shared 8x8 multiply-accumulate unit through every dot product, A·v then A·B. Each 20-bit result is written into the result memory, which the hex formatter/transmit FSM later reads. The block owns operand-read addressing, accumulation and result-write handshaking.

## Interface
Parameters:
- DATA_W, 8, operand width (unsigned)
- ACC_W, 20, accumulator/result width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse: all 36 operands loaded
- a_addr  out  4  matrix A read address (row-major, 4*row+col)
- a_data  in  DATA_W  A read data, valid one cycle after a_addr
- b_sel  out  1  0 = vector v, 1 = matrix B
- b_addr  out  4  v index (0-3) or B address (row-major)
- b_data  in  DATA_W  v/B read data, valid one cycle after b_addr/b_sel
- res_we  out  1  result write strobe, one cycle per result
- res_addr  out  5  result index: 0-3 = A·v, 4-19 = A·B (4+4r+c)
- res_data  out  ACC_W  result value, valid while res_we=1
- busy  out  1  high from cycle after accepted start to end of last write
- done  out  1  one-cycle pulse coincident with the final res_we

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start.
  - RUN issues one term per cycle.
  - RUN -> DRAIN after the last term is issued.
  - DRAIN -> IDLE after the final write.
- Dot schedule with MATVEC_EN:
  - dots 0-3: A·v row i, term k: a_addr=4i+k, b_sel=0, b_addr=k, res_addr=i.
  - dots 4-19: A·B (r,c) in row-major order: a_addr=4r+k, b_sel=1, b_addr=4k+c, res_addr=4+4r+c.
- Terms k=0..3 are issued back-to-back. Dots follow each other with no bubble.
- Pipeline (read stage, then MAC stage):
  - product = a_data*b_data, unsigned, 16 bits.
  - acc <= (k==0 ? 0 : acc) + product.
  - On k==3, res_data/res_addr are registered from that sum and res_we=1 for the next cycle.
- Width: worst case 4*255*255 = 260100 (0x3F804) fits ACC_W; no saturation or overflow handling.
- start while busy=1 is ignored.
- start with reset: reset wins.
- Reset mid-operation aborts immediately: no further res_we, state IDLE. Partially written results are left in place.
- Outputs drive valid addresses only in RUN. Outside RUN they hold their last value, and the memory ignores them.

## Timing
- Reset values: a_addr=0, b_addr=0, b_sel=0, res_we=0, res_addr=0, res_data=0, busy=0, done=0, acc=0.
- start sampled high in cycle 0 -> term addresses driven in cycles 1..N*4 (N = number of dots).
- Term data for the address issued in cycle t is consumed in cycle t+1.
- Write for a dot whose last term was issued in cycle t: res_we=1 in cycle t+2.
- First res_we in cycle 6 (res_addr 0).
- With MATVEC_EN: last addresses in cycle 80, final res_we and done in cycle 82, busy low from cycle 83.
- Without MATVEC_EN: last addresses in cycle 64, final res_we and done in cycle 66.
- A new start is accepted in the first cycle with busy=0.

## Configuration
- MATVEC_EN defined: the 20-dot schedule above, with A·v results at 0-3.
- MATVEC_EN undefined:
  - A·v is not computed and res_addr 0-3 are never written.
  - The schedule starts directly at A·B (r,c)=(0,0), with res_addr 4-19 unchanged.
  - b_sel is tied to 1.

## Test plan
- A=identity, v=(1,2,3,4), B all 2, start -> res_addr 0-3 = 1,2,3,4; res_addr 4-19 all 2; done in cycle 82.
- All operands 255 -> all 20 results 0x3F804; no overflow.
- A rows (1,2,3,4), B=identity, v=(0,0,0,1) -> A·v all 4; A·B row r = (1,2,3,4); res_we exactly 20 single-cycle pulses in cycles 6,10,...,82.
- start re-pulsed in cycle 30 while busy -> ignored; write count and values unchanged.
- reset asserted in cycle 40 -> from cycle 41 all outputs at reset values, no further res_we; a subsequent start completes normally with correct results.
- MATVEC_EN undefined, same stimulus as scenario 1 -> 16 writes to 4-19 only; first res_we in cycle 6 at res_addr 4; done in cycle 66.
